uart_echo_fifo: RTL and testbench
=================================

# uart_echo_fifo

Parametrised UART echo core: a self-contained receiver, a FIFO elastic buffer and a transmitter that re-sends every correctly framed character. Configurable frame width, baud rate and buffer depth, with a button-controlled TX pause, sticky error flags and an optional parity feature. Sits at the FPGA top level between the board's USB-UART pins and the LED bank.

## Interface
- `CLK_FREQ`, default 100_000_000: clk frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division, must be ≥ 4).
- `DATA_BITS`, default 8: data bits per frame, range 5..8.
- `FIFO_DEPTH`, default 16: entries; power of two, ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx` in 1: serial input, idle high; asynchronous to clk.
- `btn` in 1: TX pause. While high, no new frame starts.
- `tx` out 1: serial output, idle high.
- `led` out 8: last accepted character, zero-extended above `DATA_BITS`.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `ovf` out 1: sticky; a character was dropped because the FIFO was full.
- `ferr` out 1: sticky; stop bit sampled low.
- `perr` out 1: sticky parity error; constant 0 without the macro.

## Operation
- `rx` and `btn` each pass through a 2-flop synchroniser before use.
- Reset values: `tx`=1, `led`=0, `fifo_full`=0, `ovf`=0, `ferr`=0, `perr`=0; FIFO empty; both FSMs in IDLE.
- Reset is asynchronous. It aborts any frame mid-bit: `tx` returns high immediately and the FIFO contents are discarded.
- RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE → START on synchronised `rx`=0.
  - In START, the line is re-sampled at `CLKS_PER_BIT/2`. If high, the event is a glitch: return to IDLE and push nothing.
  - Data bits are sampled every `CLKS_PER_BIT` cycles after that mid-point, LSB first.
  - Stop bit sampled low: set `ferr`, drop the character, return to IDLE. The FSM waits for the line to return high before re-arming.
- Accept: a good character is pushed into the FIFO and loaded into `led` on the cycle after the stop-bit sample.
  - Push with FIFO full and no pop in the same cycle: character dropped, `ovf` set, `led` still updated.
  - Push and pop in the same cycle: always legal, count unchanged.
- TX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE. Each bit lasts exactly `CLKS_PER_BIT` cycles, data sent LSB first.
  - In IDLE, if the FIFO is not empty and synchronised `btn`=0, pop the head entry and enter START.
  - `btn` is checked only in IDLE; a frame already in progress always completes.
- Ordering: characters are echoed in arrival order. Pointers wrap modulo `FIFO_DEPTH`. A count register of width log2(`FIFO_DEPTH`)+1 distinguishes full from empty.
- Sticky flags clear only on reset.

## Timing
- Stop-bit sample edge = cycle S.
  - S+1: FIFO push, `led` update.
  - S+2: TX pops, with TX idle and `btn` low.
  - S+3: `tx` is low (start bit).
- Frame length on `tx`: (1 + `DATA_BITS` + [1] + 1) × `CLKS_PER_BIT` cycles.
- Back-to-back TX frames are separated by exactly 1 idle cycle (TX passes through IDLE for one cycle).
- `fifo_full` is registered and reflects the count after the current edge's push/pop.

## Configuration
- `UART_PARITY_EN`:
  - Defined: frames carry one even-parity bit after the data, on both RX and TX. The RX FSM checks it. A mismatched character sets `perr` and is dropped: not pushed, `led` unchanged.
  - Undefined: no parity state, and `perr` is tied to 0.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000, `BAUD`=100_000 (`CLKS_PER_BIT`=10), `FIFO_DEPTH`=16.
- Single byte: send 0xA5 on `rx` → `led`=0xA5 at S+1; `tx` falls at S+3 and carries 0xA5, 100 cycles per frame; no flags set.
- Overflow: hold `btn`=1 and send 0x00..0x10 (17 bytes) → `fifo_full`=1 after the 16th byte, `ovf`=1 after the 17th, `led`=0x10. Release `btn` → exactly 0x00..0x0F echoed, 1 idle cycle between frames.
- Framing error: send 0x3C with stop bit low → `ferr`=1, nothing echoed, `led` unchanged. A following good 0x55 echoes normally.
- Glitch: pulse `rx` low for 3 cycles → no push, `tx` stays high.
- Reset mid-frame: assert `rst`=0 during the TX data bits of 0xFF with 3 bytes queued → `tx`=1 without waiting for a clk edge, all flags 0. After release, no further output.
- Parity (macro defined): send 0x07 with odd parity bit → `perr`=1, dropped. Send 0x07 with correct parity → echoed with parity bit 1.

Source files
------------

// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: board-side signal bundle of the UART echo core.
// master = board/test side driving rx and btn, slave = the echo core.
interface uart_echo_fifo_if;
  logic       rx;
  logic       btn;
  logic       tx;
  logic [7:0] led;
  logic       fifo_full;
  logic       ovf;
  logic       ferr;
  logic       perr;

  modport master (
    output rx, btn,
    input  tx, led, fifo_full, ovf, ferr, perr
  );

  modport slave (
    input  rx, btn,
    output tx, led, fifo_full, ovf, ferr, perr
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: UART receiver -> FIFO elastic buffer -> UART transmitter.
// Every correctly framed character is echoed in arrival order; btn pauses new
// TX frames. Optional even-parity framing on RX and TX: define UART_PARITY_EN.
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | line idle; re-arms only after the line has been seen high
//   RX_START  | wait half a bit, reject the start edge if the line is high
//   RX_DATA   | sample DATA_BITS bits, LSB first, one per bit period
//   RX_PARITY | sample and check the even-parity bit (UART_PARITY_EN only)
//   RX_STOP   | sample stop bit; high = accept, low = framing error
// TX FSM
//   state     | meaning
//   TX_IDLE   | pop the FIFO head when not empty and btn is low
//   TX_START  | drive the start bit
//   TX_DATA   | drive DATA_BITS bits, LSB first
//   TX_PARITY | drive the even-parity bit (UART_PARITY_EN only)
//   TX_STOP   | drive the stop bit
module uart_echo_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic             clk,
  input logic             rst,
  uart_echo_fifo_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  logic r_rx_meta, r_rx_sync, r_btn_meta, r_btn_sync;

  rx_state_t            r_rx_state, w_rx_next;
  logic [CW-1:0]        r_rx_cnt;
  logic [BW-1:0]        r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_armed, r_rx_valid, r_ferr;
  logic                 w_rx_tick, w_par_ok;

  tx_state_t            r_tx_state, w_tx_next;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par, r_tx;
  logic                 w_tx_tick, w_pop;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]        r_count, w_count_next;
  logic                 r_full, r_ovf, w_wr_en;
  logic [7:0]           r_led;

  // two-flop synchronisers for the asynchronous rx line and the pause button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_rx_meta  <= bus.rx;
      r_rx_sync  <= r_rx_meta;
      r_btn_meta <= bus.btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  // ---------------------------------------------------------------- receiver
  assign w_rx_tick = (r_rx_cnt == '0);

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_state <= RX_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  // RX next-state logic
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (r_rx_armed && !r_rx_sync) w_rx_next = RX_START;
      RX_START:  if (w_rx_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (w_rx_tick && (r_rx_bit == '0)) begin
`ifdef UART_PARITY_EN
          w_rx_next = RX_PARITY;
`else
          w_rx_next = RX_STOP;
`endif
        end
`ifdef UART_PARITY_EN
      RX_PARITY: if (w_rx_tick) w_rx_next = RX_STOP;
`endif
      RX_STOP:   if (w_rx_tick) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  // RX bit timer, data shift, accept strobe and framing-error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_cnt   <= HALF_LAST;
      r_rx_bit   <= DBIT_LAST;
      r_rx_shift <= '0;
      r_rx_armed <= 1'b0;
      r_rx_valid <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_rx_state == RX_IDLE) begin
        // first sample lands mid start bit, the rest one bit period apart
        r_rx_cnt <= HALF_LAST;
        r_rx_bit <= DBIT_LAST;
        if (r_rx_sync) r_rx_armed <= 1'b1;
      end else begin
        r_rx_cnt <= w_rx_tick ? BIT_LAST : r_rx_cnt - 1'b1;
      end
      if (w_rx_tick) begin
        case (r_rx_state)
          RX_DATA: begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit - 1'b1;
          end
          RX_STOP: begin
            if (r_rx_sync) begin
              r_rx_valid <= w_par_ok;
            end else begin
              // a low stop bit may be a break; wait for idle before re-arming
              r_ferr     <= 1'b1;
              r_rx_armed <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_PARITY_EN
  logic r_perr, r_rx_par_ok;

  // even parity: data plus parity bit must carry an even number of ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr      <= 1'b0;
      r_rx_par_ok <= 1'b0;
    end else if ((r_rx_state == RX_PARITY) && w_rx_tick) begin
      r_rx_par_ok <= ~((^r_rx_shift) ^ r_rx_sync);
      if ((^r_rx_shift) ^ r_rx_sync) r_perr <= 1'b1;
    end
  end

  assign w_par_ok = r_rx_par_ok;
  assign bus.perr = r_perr;
`else
  assign w_par_ok = 1'b1;
  assign bus.perr = 1'b0;
`endif

  // -------------------------------------------------------------------- FIFO
  assign w_wr_en = r_rx_valid && (!r_full || w_pop);

  // occupancy after this edge's push/pop
  always_comb begin
    w_count_next = r_count;
    if (w_wr_en && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_wr_en && w_pop) w_count_next = r_count - 1'b1;
  end

  // pointers, occupancy, full/overflow flags and the LED copy of each accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_led    <= 8'h00;
    end else begin
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_FULL);
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_rx_valid) begin
        r_led <= 8'(r_rx_shift);
        if (!w_wr_en) r_ovf <= 1'b1;
      end
    end
  end

  // storage needs no reset: the pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_rx_shift;
  end

  // ------------------------------------------------------------- transmitter
  assign w_tx_tick = (r_tx_cnt == '0);
  assign w_pop     = (r_tx_state == TX_IDLE) && (r_count != '0) && !r_btn_sync;

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_state <= TX_IDLE;
    else      r_tx_state <= w_tx_next;
  end

  // TX next-state logic
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:   if (w_pop) w_tx_next = TX_START;
      TX_START:  if (w_tx_tick) w_tx_next = TX_DATA;
      TX_DATA:
        if (w_tx_tick && (r_tx_bit == '0)) begin
`ifdef UART_PARITY_EN
          w_tx_next = TX_PARITY;
`else
          w_tx_next = TX_STOP;
`endif
        end
`ifdef UART_PARITY_EN
      TX_PARITY: if (w_tx_tick) w_tx_next = TX_STOP;
`endif
      TX_STOP:   if (w_tx_tick) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end

  // TX bit timer, data shift and registered line driver (one cycle behind state)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_cnt   <= BIT_LAST;
      r_tx_bit   <= DBIT_LAST;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_START:  r_tx <= 1'b0;
        TX_DATA:   r_tx <= r_tx_shift[0];
`ifdef UART_PARITY_EN
        TX_PARITY: r_tx <= r_tx_par;
`endif
        default:   r_tx <= 1'b1;
      endcase
      if (r_tx_state == TX_IDLE) begin
        r_tx_cnt <= BIT_LAST;
        r_tx_bit <= DBIT_LAST;
        if (w_pop) begin
          r_tx_shift <= r_mem[r_rd_ptr];
          r_tx_par   <= ^r_mem[r_rd_ptr];
        end
      end else begin
        r_tx_cnt <= w_tx_tick ? BIT_LAST : r_tx_cnt - 1'b1;
        if (w_tx_tick && (r_tx_state == TX_DATA)) begin
          r_tx_shift <= r_tx_shift >> 1;
          r_tx_bit   <= r_tx_bit - 1'b1;
        end
      end
    end
  end

  assign bus.tx        = r_tx;
  assign bus.led       = r_led;
  assign bus.fifo_full = r_full;
  assign bus.ovf       = r_ovf;
  assign bus.ferr      = r_ferr;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed bench for uart_echo_fifo at 10 clocks per bit.
// A serial monitor decodes every frame on tx into queues; expectations come
// from the vector table and hand-written sequences below.
module tb_uart_echo_fifo;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DB       = 8;
  localparam int DEPTH    = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = (1 + DB + PB + 1) * CPB;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    logic [7:0] exp_led;
    bit         exp_echo;
    bit         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   low_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] echo_q[$];
  logic       frm_q[$];
  logic       par_q[$];
  int         fall_q[$];

  vec_t vecs[6];

  uart_echo_fifo_if bus();

  uart_echo_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst && bus.tx == 1'b0) low_cnt <= low_cnt + 1;

  initial begin : tx_monitor
    logic [7:0] d;
    logic       ok;
    logic       p;
    forever begin
      @(negedge clk);
      if (rst && bus.tx === 1'b0) begin
        fall_q.push_back(cyc);
        d = 8'h00;
        p = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        ok = (bus.tx == 1'b0);
        for (int i = 0; i < DB; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = bus.tx;
        end
        if (PB == 1) begin
          repeat (CPB) @(negedge clk);
          p = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        ok = ok && (bus.tx == 1'b1);
        echo_q.push_back(d);
        frm_q.push_back(ok);
        par_q.push_back(p);
      end
    end
  end

  initial begin : watchdog
    #(10 * 100_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input bit par_bad);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PB == 1) begin
      bus.rx = (^d) ^ par_bad;
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_ok;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic check_echo(input string name, input int idx, input logic [7:0] exp);
    if (echo_q.size() > idx) begin
      check({name, "_data"}, int'(echo_q[idx]), int'(exp));
      check({name, "_framing"}, int'(frm_q[idx]), 1);
    end else begin
      check({name, "_present"}, echo_q.size(), idx + 1);
    end
  endtask

  task automatic wait_fall(input int f0, input int limit);
    for (int k = 0; k < limit && fall_q.size() == f0; k++) @(negedge clk);
  endtask

  initial begin : main
    int n0;
    int f0;
    int base_low;
    int c_led;

    vecs[0] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 8'h55, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b1};

    bus.rx  = 1'b1;
    bus.btn = 1'b0;
    rst     = 1'b0;
    wait_cycles(3);
    check("rst_tx", int'(bus.tx), 1);
    check("rst_led", int'(bus.led), 0);
    check("rst_full", int'(bus.fifo_full), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_ferr", int'(bus.ferr), 0);
    check("rst_perr", int'(bus.perr), 0);
    rst = 1'b1;
    wait_cycles(5);

    // single byte: led at S+1, start bit on tx two cycles later
    n0 = echo_q.size();
    f0 = fall_q.size();
    c_led = -1;
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        for (int k = 0; k < FRAME + 40; k++) begin
          @(negedge clk);
          if (bus.led == 8'hA5) begin
            c_led = cyc;
            break;
          end
        end
      end
    join
    wait_fall(f0, 40);
    check("a5_led_seen", int'(c_led >= 0), 1);
    check("a5_tx_fall", fall_q.size(), f0 + 1);
    if (fall_q.size() > f0) check("a5_led_to_tx_latency", fall_q[f0] - c_led, 2);
    wait_cycles(FRAME + 20);
    check_echo("a5_echo", n0, 8'hA5);
    check("a5_echo_count", echo_q.size(), n0 + 1);
    check("a5_ferr", int'(bus.ferr), 0);
    check("a5_ovf", int'(bus.ovf), 0);

    // table of single characters, including a framing error
    for (int v = 0; v < 6; v++) begin
      n0 = echo_q.size();
      send_byte(vecs[v].data, vecs[v].stop_ok, 1'b0);
      wait_cycles(4);
      check($sformatf("vec%0d_led", v), int'(bus.led), int'(vecs[v].exp_led));
      check($sformatf("vec%0d_ferr", v), int'(bus.ferr), int'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovf", v), int'(bus.ovf), 0);
      wait_cycles(FRAME + 20);
      check($sformatf("vec%0d_echo_count", v), echo_q.size(), n0 + int'(vecs[v].exp_echo));
      if (vecs[v].exp_echo) check_echo($sformatf("vec%0d_echo", v), n0, vecs[v].data);
    end

    // glitch: 3-cycle low pulse must not start a frame
    base_low = low_cnt;
    bus.rx = 1'b0;
    wait_cycles(3);
    bus.rx = 1'b1;
    wait_cycles(FRAME + 40);
    check("glitch_tx_low_cycles", low_cnt - base_low, 0);
    check("glitch_led", int'(bus.led), 8'h80);

    // overflow: 17 bytes while paused, then 16 echoed back to back
    n0 = echo_q.size();
    f0 = fall_q.size();
    bus.btn = 1'b1;
    wait_cycles(4);
    base_low = low_cnt;
    for (int b = 0; b < 17; b++) begin
      send_byte(8'(b), 1'b1, 1'b0);
      wait_cycles(2);
      if (b == 14) check("ovf_full_at_15", int'(bus.fifo_full), 0);
      if (b == 15) begin
        check("ovf_full_at_16", int'(bus.fifo_full), 1);
        check("ovf_flag_at_16", int'(bus.ovf), 0);
      end
      if (b == 16) begin
        check("ovf_full_at_17", int'(bus.fifo_full), 1);
        check("ovf_flag_at_17", int'(bus.ovf), 1);
        check("ovf_led_at_17", int'(bus.led), 8'h10);
      end
    end
    check("ovf_paused_tx_low_cycles", low_cnt - base_low, 0);
    bus.btn = 1'b0;
    wait_cycles(17 * (FRAME + 1) + 60);
    check("ovf_echo_count", echo_q.size(), n0 + 16);
    for (int i = 0; i < 16; i++) check_echo($sformatf("ovf_echo%0d", i), n0 + i, 8'(i));
    for (int i = 0; i < 15; i++)
      if (fall_q.size() > f0 + i + 1)
        check($sformatf("ovf_gap%0d", i), fall_q[f0 + i + 1] - fall_q[f0 + i], FRAME + 1);
    check("ovf_full_after_drain", int'(bus.fifo_full), 0);
    check("ovf_sticky", int'(bus.ovf), 1);

    // reset during the data bits of 0xFF with 3 bytes queued
    bus.btn = 1'b1;
    wait_cycles(4);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    wait_cycles(2);
    f0 = fall_q.size();
    bus.btn = 1'b0;
    wait_fall(f0, 40);
    check("rstmid_frame_started", fall_q.size(), f0 + 1);
    wait_cycles(CPB / 2 + 3 * CPB);
    #2 rst = 1'b0;
    #1;
    check("rstmid_tx", int'(bus.tx), 1);
    check("rstmid_led", int'(bus.led), 0);
    check("rstmid_full", int'(bus.fifo_full), 0);
    check("rstmid_ovf", int'(bus.ovf), 0);
    check("rstmid_ferr", int'(bus.ferr), 0);
    check("rstmid_perr", int'(bus.perr), 0);
    @(negedge clk);
    wait_cycles(3);
    rst = 1'b1;
    base_low = low_cnt;
    wait_cycles(4 * (FRAME + 1));
    check("rstmid_no_output", low_cnt - base_low, 0);

    // reset asserted between clock edges during a start bit
    f0 = fall_q.size();
    send_byte(8'h00, 1'b1, 1'b0);
    wait_fall(f0, 40);
    check("astart_frame_started", fall_q.size(), f0 + 1);
    wait_cycles(2);
    check("astart_tx_low_before", int'(bus.tx), 0);
    #2 rst = 1'b0;
    #1;
    check("astart_tx_async_high", int'(bus.tx), 1);
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(FRAME + 20);

`ifdef UART_PARITY_EN
    // parity: bad parity dropped, good parity echoed with parity bit 1
    n0 = echo_q.size();
    send_byte(8'h07, 1'b1, 1'b1);
    wait_cycles(4);
    check("par_bad_perr", int'(bus.perr), 1);
    check("par_bad_led", int'(bus.led), 0);
    check("par_bad_ferr", int'(bus.ferr), 0);
    wait_cycles(FRAME + 20);
    check("par_bad_no_echo", echo_q.size(), n0);
    send_byte(8'h07, 1'b1, 1'b0);
    wait_cycles(4);
    check("par_good_led", int'(bus.led), 8'h07);
    wait_cycles(FRAME + 20);
    check_echo("par_good_echo", n0, 8'h07);
    if (par_q.size() > n0) check("par_good_bit", int'(par_q[n0]), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
